poly_sample_gen: RTL and testbench

//  Upstream stage of the integration datapath. Latches polynomial coefficients a, b, c
//  and a start abscissa x0, then streams f(x) = a*x^2 + b*x + c for
//  x = x0, x0+1, ..., x0+N-1 over a valid/ready interface to the integration accumulator.

---
 rtl/poly_sample_gen.sv | 114 +++++++++++
 tb/tb_poly_sample_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_sample_gen.sv
// Streams f(x) = a*x^2 + b*x + c for x = x0 .. x0+N-1 over valid/ready.
// Two Horner multiplies at start, then forward differences (adds only) per sample.
module poly_sample_gen #(
  parameter int DATA_W = 33,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 80
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] x0,
  input  logic        [CNT_W-1:0]  n_samples,
  output logic                     busy,
  output logic                     done,
  output logic                     s_valid,
  input  logic                     s_ready,
  output logic signed [ACC_W-1:0]  s_data,
  output logic        [CNT_W-1:0]  s_index,
  output logic                     s_last
);

  typedef enum logic [2:0] {IDLE, INIT1, INIT2, STREAM, DONE} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  coefA;
  logic signed [ACC_W-1:0]  coefB;
  logic signed [ACC_W-1:0]  coefC;
  logic signed [ACC_W-1:0]  xStart;
  logic signed [ACC_W-1:0]  prodT;
  logic signed [ACC_W-1:0]  diff1;
  logic signed [ACC_W-1:0]  diff2;
  logic        [CNT_W-1:0]  nLat;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // A streamed run raises done on its final handshake; an empty run has no
  // handshake, so its pulse comes out of the DONE state instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      s_data  <= '0;
      s_index <= '0;
      coefA   <= '0;
      coefB   <= '0;
      coefC   <= '0;
      xStart  <= '0;
      prodT   <= '0;
      diff1   <= '0;
      diff2   <= '0;
      nLat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            coefA  <= sext(a);
            coefB  <= sext(b);
            coefC  <= sext(c);
            xStart <= sext(x0);
            nLat   <= n_samples;
            busy   <= 1'b1;
            state  <= (n_samples == '0) ? DONE : INIT1;
          end
        end
        INIT1: begin
          prodT <= coefA * xStart;
          state <= INIT2;
        end
        INIT2: begin
          s_data  <= (prodT + coefB) * xStart + coefC;
          diff1   <= (prodT <<< 1) + coefA + coefB;
          diff2   <= coefA <<< 1;
          s_index <= '0;
          s_valid <= 1'b1;
          s_last  <= (nLat == CNT_W'(1));
          state   <= STREAM;
        end
        STREAM: begin
          if (s_valid && s_ready) begin
            s_data  <= s_data + diff1;
            diff1   <= diff1 + diff2;
            s_index <= s_index + CNT_W'(1);
            if (s_index == nLat - CNT_W'(1)) begin
              s_valid <= 1'b0;
              s_last  <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              s_last <= (s_index + CNT_W'(1) == nLat - CNT_W'(1));
            end
          end
        end
        DONE: begin
          done  <= ~done;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sample_gen.sv
// Scoreboard bench for poly_sample_gen: expected samples come from direct
// evaluation of a*x^2 + b*x + c and are popped by an independent monitor.
module tb_poly_sample_gen;

  localparam int DATA_W = 33;
  localparam int CNT_W  = 16;
  localparam int ACC_W  = 80;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic signed [DATA_W-1:0] a = '0;
  logic signed [DATA_W-1:0] b = '0;
  logic signed [DATA_W-1:0] c = '0;
  logic signed [DATA_W-1:0] x0 = '0;
  logic        [CNT_W-1:0]  n_samples = '0;
  logic                     busy;
  logic                     done;
  logic                     s_valid;
  logic                     s_ready = 1'b1;
  logic signed [ACC_W-1:0]  s_data;
  logic        [CNT_W-1:0]  s_index;
  logic                     s_last;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] index;
    logic             last;
  } sample_t;

  sample_t expQ[$];
  sample_t held;
  logic    stalled = 1'b0;
  int      errors = 0;
  int      checks = 0;
  int      cycleCnt = 0;
  int      startCycle = -10;
  int      doneCount = 0;
  int      doneAtStart = 0;
  int      doneCycle = -10;
  int      firstValidCycle = -1;
  int      handshakes = 0;
  int      readyMode = 0;
  int      patCnt = 0;
  logic    busyC1 = 1'b0;
  logic    busyAtDone = 1'b0;
  logic    busyAfterDone = 1'b1;

  poly_sample_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .x0(x0), .n_samples(n_samples),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_index(s_index), .s_last(s_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  always @(posedge clk) begin
    #1;
    case (readyMode)
      1: begin
        s_ready = (patCnt % 3 == 0);
        patCnt++;
      end
      2: s_ready = 1'($urandom_range(0, 1));
      default: s_ready = 1'b1;
    endcase
  end

  function automatic logic [ACC_W-1:0] polyRef(input logic signed [DATA_W-1:0] pa,
                                               input logic signed [DATA_W-1:0] pb,
                                               input logic signed [DATA_W-1:0] pc,
                                               input logic signed [DATA_W-1:0] px0,
                                               input int k);
    logic signed [ACC_W-1:0] ea, eb, ec, x;
    ea = pa;
    eb = pb;
    ec = pc;
    x  = px0;
    x  = x + ACC_W'(k);
    return ea * x * x + eb * x + ec;
  endfunction

  function automatic logic [DATA_W-1:0] rnd33();
    logic [31:0] lo;
    logic        hi;
    lo = $urandom();
    hi = 1'($urandom_range(0, 1));
    return {hi, lo};
  endfunction

  task automatic checkOutput(input string name, input logic [ACC_W-1:0] actual,
                             input logic [ACC_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and watches stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (stalled) begin
        checks++;
        if (!s_valid || {s_data, s_index, s_last} !== held) begin
          errors++;
          $display("[TB] FAIL stall_hold: got v=%0b %0h/%0d/%0b expected %0h/%0d/%0b",
                   s_valid, s_data, s_index, s_last, held.data, held.index, held.last);
        end
      end
      if (s_valid) begin
        if (firstValidCycle < 0) firstValidCycle = cycleCnt;
        if (s_ready) begin
          sample_t e;
          handshakes++;
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL sample: got %0h idx %0d with no sample expected", s_data, s_index);
          end else begin
            e = expQ.pop_front();
            if ({s_data, s_index, s_last} !== e) begin
              errors++;
              $display("[TB] FAIL sample: got %0h idx %0d last %0b expected %0h idx %0d last %0b",
                       s_data, s_index, s_last, e.data, e.index, e.last);
            end
          end
        end
        stalled = !s_ready;
        held = {s_data, s_index, s_last};
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        doneCount++;
        doneCycle = cycleCnt;
        busyAtDone = busy;
      end
      if (cycleCnt == doneCycle + 1) busyAfterDone = busy;
      if (cycleCnt == startCycle + 1) busyC1 = busy;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic applyStimulus(input logic signed [DATA_W-1:0] pa, input logic signed [DATA_W-1:0] pb,
                               input logic signed [DATA_W-1:0] pc, input logic signed [DATA_W-1:0] px0,
                               input int n);
    int budget = 0;
    while (busy && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("[TB] FAIL idle_wait: got busy=1 expected 0");
    end
    @(posedge clk);
    #1;
    a = pa; b = pb; c = pc; x0 = px0; n_samples = CNT_W'(n);
    start = 1'b1;
    startCycle = cycleCnt;
    firstValidCycle = -1;
    doneAtStart = doneCount;
    for (int k = 0; k < n; k++)
      expQ.push_back({polyRef(pa, pb, pc, px0, k), CNT_W'(k), 1'(k == n - 1)});
    @(posedge clk);
    #1;
    start = 1'b0;
    a = rnd33(); b = rnd33(); c = rnd33(); x0 = rnd33();
    n_samples = CNT_W'($urandom_range(1, 20));
  endtask

  task automatic waitDone(input int n, input bit timing);
    int budget = 0;
    while (doneCount == doneAtStart && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (doneCount == doneAtStart) begin
      errors++;
      checks++;
      $display("[TB] FAIL done_timeout: got no done expected one");
      return;
    end
    repeat (3) @(posedge clk);
    checkOutput("done_pulses", ACC_W'(doneCount - doneAtStart), ACC_W'(1));
    checkOutput("queue_left", ACC_W'(expQ.size()), ACC_W'(0));
    checkOutput("busy_cycle1", ACC_W'(busyC1), ACC_W'(1));
    checkOutput("busy_at_done", ACC_W'(busyAtDone), ACC_W'(n != 0));
    checkOutput("busy_after_done", ACC_W'(busyAfterDone), ACC_W'(0));
    if (timing) begin
      checkOutput("done_cycle", ACC_W'(doneCycle - startCycle), ACC_W'(n == 0 ? 2 : 3 + n));
      checkOutput("first_valid", ACC_W'(firstValidCycle - startCycle),
                  (n == 0) ? ACC_W'(-1 - startCycle) : ACC_W'(3));
    end
  endtask

  initial begin
    int hs0;
    int budget;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", ACC_W'(s_valid), ACC_W'(0));
    checkOutput("reset_busy", ACC_W'(busy), ACC_W'(0));
    checkOutput("reset_done", ACC_W'(done), ACC_W'(0));
    checkOutput("reset_last", ACC_W'(s_last), ACC_W'(0));
    checkOutput("reset_data", s_data, ACC_W'(0));
    checkOutput("reset_index", ACC_W'(s_index), ACC_W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] squares from zero");
    applyStimulus(33'sd1, 33'sd0, 33'sd0, 33'sd0, 4);
    waitDone(4, 1'b1);

    $display("[TB] signed coefficients");
    applyStimulus(33'sd2, -33'sd3, 33'sd5, -33'sd2, 3);
    waitDone(3, 1'b1);

    $display("[TB] stalled downstream");
    readyMode = 1;
    patCnt = 0;
    applyStimulus(33'sd1, 33'sd0, 33'sd0, 33'sd0, 4);
    waitDone(4, 1'b0);
    readyMode = 0;

    $display("[TB] empty run");
    applyStimulus(33'sd9, 33'sd9, 33'sd9, 33'sd9, 0);
    waitDone(0, 1'b1);

    $display("[TB] reset mid-run");
    hs0 = handshakes;
    applyStimulus(33'sd3, 33'sd1, -33'sd4, 33'sd6, 10);
    budget = 0;
    while (handshakes < hs0 + 2 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("hs_before_reset", ACC_W'(handshakes - hs0), ACC_W'(2));
    #1;
    rst = 1'b1;
    expQ.delete();
    doneAtStart = doneCount;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", ACC_W'(s_valid), ACC_W'(0));
    checkOutput("abort_busy", ACC_W'(busy), ACC_W'(0));
    checkOutput("abort_done", ACC_W'(done), ACC_W'(0));
    repeat (4) @(posedge clk);
    checkOutput("abort_no_done", ACC_W'(doneCount - doneAtStart), ACC_W'(0));
    applyStimulus(33'sd0, 33'sd0, 33'sd7, 33'sd11, 2);
    waitDone(2, 1'b1);

    $display("[TB] start while busy");
    applyStimulus(-33'sd5, 33'sd8, 33'sd1, 33'sd3, 5);
    @(posedge clk);
    #1;
    a = 33'sd100; b = 33'sd200; c = 33'sd300; x0 = 33'sd400; n_samples = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(5, 1'b1);
    repeat (5) @(posedge clk);
    checkOutput("no_extra_run", ACC_W'(busy), ACC_W'(0));

    $display("[TB] randomized runs");
    readyMode = 2;
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 6);
      applyStimulus(rnd33(), rnd33(), rnd33(), rnd33(), n);
      waitDone(n, 1'b0);
    end
    readyMode = 0;

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
